// File: rtl/mlp_acc_pkg.sv
// Shared types and width helpers for the MLP dense accumulate/requant block.
// Used by mlp_requant_sat and mlp_dense_acc_requant.
package mlp_acc_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FINAL = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_PROD_WIDTH = 31;
  localparam int DEF_N_IN       = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_BIAS_WIDTH = 16;
  localparam int DEF_SHIFT      = 10;
  localparam int DEF_OUT_WIDTH  = 16;

  function automatic int mlp_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Smallest accumulator that can sum n_in full-scale products without wrap.
  function automatic int acc_min_width(input int pw, input int n_in);
    return pw + mlp_clog2(n_in) + 1;
  endfunction

  function automatic int cnt_width(input int n_in);
    return (mlp_clog2(n_in) < 1) ? 1 : mlp_clog2(n_in);
  endfunction

endpackage

// File: rtl/mlp_requant_sat.sv
// Combinational bias add, round-half-up, arithmetic shift and saturation.
// Optional fused ReLU when MLP_ACC_RELU_EN is defined.
module mlp_requant_sat
  import mlp_acc_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [BIAS_WIDTH-1:0] bias_i,
  output logic [OUT_WIDTH-1:0]  y_o
);

  localparam int BSW = BIAS_WIDTH + SHIFT;
  localparam int RW  = ((ACC_WIDTH > BSW) ? ACC_WIDTH : BSW) + 2;

  localparam logic signed [RW-1:0] RND =
    RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV =
    {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [RW-1:0] acc_x;
  logic signed [RW-1:0] bias_x;
  logic signed [RW-1:0] bias_s;
  logic signed [RW-1:0] r;
  logic signed [RW-1:0] y;
  logic [OUT_WIDTH-1:0] sat;

  always_comb begin
    acc_x  = {{(RW-ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
    bias_x = {{(RW-BIAS_WIDTH){bias_i[BIAS_WIDTH-1]}}, bias_i};
    bias_s = bias_x <<< SHIFT;
    r      = acc_x + bias_s + RND;
    y      = r >>> SHIFT;
  end

  always_comb begin
    sat = y[OUT_WIDTH-1:0];
    if (y > MAXV) begin
      sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (y < MINV) begin
      sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

`ifdef MLP_ACC_RELU_EN
  assign y_o = sat[OUT_WIDTH-1] ? '0 : sat;
`else
  assign y_o = sat;
`endif

endmodule

// File: rtl/mlp_dense_acc_requant.sv
// Per-neuron product accumulator with bias, requant and output handshake.
// Build option MLP_ACC_RELU_EN fuses a ReLU into the requant stage.
module mlp_dense_acc_requant
  import mlp_acc_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int N_IN       = DEF_N_IN,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  input  logic [BIAS_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_last
);

  localparam int CW = cnt_width(N_IN);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);

  if (ACC_WIDTH < acc_min_width(PROD_WIDTH, N_IN)) begin : g_acc_w_err
    $error("ACC_WIDTH too small for PROD_WIDTH and N_IN");
  end
  if (N_IN < 2) begin : g_n_in_err
    $error("N_IN must be at least 2");
  end
  if (SHIFT < 1 || SHIFT > ACC_WIDTH - OUT_WIDTH) begin : g_shift_err
    $error("SHIFT out of range");
  end

  state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;

  logic [ACC_WIDTH-1:0]  prod_x;
  logic [OUT_WIDTH-1:0]  rq_y;
  logic                  cnt_last;

  assign prod_x = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}},
                   prod_data};
  assign cnt_last = (cnt_q == CNT_LAST);

  mlp_requant_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .BIAS_WIDTH (BIAS_WIDTH),
    .SHIFT      (SHIFT),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_rq (
    .acc_i  (acc_q),
    .bias_i (bias),
    .y_o    (rq_y)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    prod_ready  = 1'b0;
    unique case (state_q)
      ST_ACC: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          acc_d = acc_q + prod_x;
          // The count decides the neuron boundary; prod_last is only audited.
          if (prod_last != cnt_last) err_d = 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_FINAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FINAL: begin
        out_data_d  = rq_y;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_last  = err_q;

endmodule

// File: tb/tb_mlp_dense_acc_requant.sv
// Directed bench for mlp_dense_acc_requant: vector table plus
// handshake, prod_last and mid-neuron reset sequences.
module tb_mlp_dense_acc_requant;

  logic               ap_clk;
  logic               ap_rst;
  logic signed [30:0] prod_data;
  logic               prod_valid;
  logic               prod_last;
  logic               prod_ready;
  logic signed [15:0] bias;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               err_last;

  int errors = 0;
  int checks = 0;

  mlp_dense_acc_requant dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .bias       (bias),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_last   (err_last)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string              name;
    logic signed [30:0] p;
    logic signed [15:0] b;
    int                 e;
  } vec_t;

  vec_t vecs[12];

  function automatic int relu(input int x);
`ifdef MLP_ACC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!prod_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    chk({name, "_ready"}, prod_ready, 1);
  endtask

  task automatic send_neuron(input string name,
                             input logic signed [30:0] p,
                             input logic signed [15:0] b,
                             input int last_at,
                             input int exp,
                             input int hold,
                             input bit exp_err);
    bias = b;
    for (int i = 0; i < 16; i++) begin
      @(negedge ap_clk);
      if (i == 0) wait_ready(name);
      prod_valid = 1'b1;
      prod_data  = p;
      prod_last  = (i == last_at);
    end
    @(negedge ap_clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    chk({name, "_valid_t1"}, out_valid, 0);
    chk({name, "_pready_t1"}, prod_ready, 0);
    @(negedge ap_clk);
    chk({name, "_valid_t2"}, out_valid, 1);
    chk({name, "_data"}, out_data, relu(exp));
    chk({name, "_err"}, err_last, exp_err);
    for (int h = 0; h < hold; h++) begin
      prod_valid = 1'b1;
      prod_data  = 31'sd12345;
      @(negedge ap_clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_data"}, out_data, relu(exp));
      chk({name, "_hold_pready"}, prod_ready, 0);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, out_valid, 0);
    chk({name, "_pready_back"}, prod_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"p1024",    31'sd1024,        16'sd0,      16};
    vecs[1]  = '{"pmax",     31'sd1073741823,  16'sd0,      32767};
    vecs[2]  = '{"pm1024",   -31'sd1024,       16'sd0,      -16};
    vecs[3]  = '{"pmin",     -31'sd1073741824, 16'sd0,      -32768};
    vecs[4]  = '{"bias5",    31'sd0,           16'sd5,      5};
    vecs[5]  = '{"half32",   31'sd32,          16'sd0,      1};
    vecs[6]  = '{"below31",  31'sd31,          16'sd0,      0};
    vecs[7]  = '{"neghalf",  -31'sd32,         16'sd0,      0};
    vecs[8]  = '{"neg33",    -31'sd33,         16'sd0,      -1};
    vecs[9]  = '{"mixbias",  31'sd100,         -16'sd3,     -1};
    vecs[10] = '{"biasmin",  31'sd0,           -16'sd32768, -32768};
    vecs[11] = '{"biassat",  31'sd1024,        16'sd32767,  32767};

    ap_rst     = 1'b1;
    prod_data  = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    bias       = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_last", err_last, 0);
    chk("rst_prod_ready", prod_ready, 1);

    for (int v = 0; v < 12; v++) begin
      send_neuron(vecs[v].name, vecs[v].p, vecs[v].b, 15, vecs[v].e, 0, 1'b0);
    end

    send_neuron("hold5", 31'sd1024, 16'sd0, 15, 16, 5, 1'b0);
    send_neuron("after_hold", 31'sd2, 16'sd1, 15, 1, 0, 1'b0);

    send_neuron("last_early", 31'sd1024, 16'sd0, 2, 16, 0, 1'b1);
    send_neuron("err_sticky", -31'sd1024, 16'sd0, 15, -16, 0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      @(negedge ap_clk);
      prod_valid = 1'b1;
      prod_data  = 31'sd1024;
      prod_last  = 1'b0;
    end
    @(negedge ap_clk);
    prod_valid = 1'b0;
    ap_rst     = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("midrst_err", err_last, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", prod_ready, 1);
    send_neuron("post_rst", 31'sd1024, 16'sd0, 15, 16, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
